// File: rtl/imm_extend_pipe_pkg.sv
// Shared definitions for the immediate-extension pipeline: format encoding and raw field width.
package imm_extend_pipe_pkg;

   localparam int RAW_W = 25;

   typedef enum logic [2:0] {
      IMM_I = 3'b000,
      IMM_S = 3'b001,
      IMM_B = 3'b010,
      IMM_U = 3'b011,
      IMM_J = 3'b100
   } imm_src_e;

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Request/result bundle for imm_extend_pipe; slave is the pipeline's view, master the user's.
interface imm_extend_pipe_if #(
   parameter int XLEN      = 32,
   parameter int ERR_CNT_W = 8
);
   import imm_extend_pipe_pkg::*;

   logic                 in_valid;
   logic                 in_ready;
   logic [RAW_W-1:0]     raw_code;
   logic [2:0]           imm_src;
   logic                 out_valid;
   logic                 out_ready;
   logic [XLEN-1:0]      extend_imm;
   logic [2:0]           out_src;
   logic                 illegal;
   logic [ERR_CNT_W-1:0] err_count;

   modport slave (
      input  in_valid, raw_code, imm_src, out_ready,
      output in_ready, out_valid, extend_imm, out_src, illegal, err_count
   );

   modport master (
      output in_valid, raw_code, imm_src, out_ready,
      input  in_ready, out_valid, extend_imm, out_src, illegal, err_count
   );
endinterface

// File: rtl/imm_extend_pipe_decode.sv
// Combinational RISC-V immediate decode: reassembles the format's fields and sign-extends to XLEN.
module imm_decode
   import imm_extend_pipe_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [RAW_W-1:0] raw_code,
   input  logic [2:0]       imm_src,
   output logic [XLEN-1:0]  extend_imm,
   output logic             illegal
);

   // Signed casts to XLEN perform the sign extension from each format's top bit.
   always_comb begin
      extend_imm = '0;
      illegal    = 1'b0;
      case (imm_src)
         IMM_I: extend_imm = XLEN'($signed(raw_code[24:13]));
         IMM_S: extend_imm = XLEN'($signed({raw_code[24:18], raw_code[4:0]}));
         IMM_B: extend_imm = XLEN'($signed({raw_code[24], raw_code[0], raw_code[23:18],
                                            raw_code[4:1], 1'b0}));
         IMM_U: extend_imm = XLEN'($signed({raw_code[24:5], 12'b0}));
         IMM_J: extend_imm = XLEN'($signed({raw_code[24], raw_code[12:5], raw_code[13],
                                            raw_code[23:14], 1'b0}));
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/imm_extend_pipe.sv
// Immediate-extension pipeline: decode feeding a two-entry skid buffer, plus an illegal-format counter.
module imm_extend_pipe #(
   parameter int XLEN      = 32,
   parameter int ERR_CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   imm_extend_pipe_if.slave bus
);

   logic [XLEN-1:0]      w_dec_imm;
   logic                 w_dec_illegal;
   logic                 w_accept;
   logic                 w_skid_load;
   logic                 w_skid_drain;
   logic                 w_skid_valid_next;

   logic                 r_in_ready;
   logic                 r_out_valid;
   logic [XLEN-1:0]      r_out_imm;
   logic [2:0]           r_out_src;
   logic                 r_out_illegal;
   logic                 r_skid_valid;
   logic [XLEN-1:0]      r_skid_imm;
   logic [2:0]           r_skid_src;
   logic                 r_skid_illegal;
   logic [ERR_CNT_W-1:0] r_err_count;

   imm_decode #(.XLEN(XLEN)) u_decode (
      .raw_code   (bus.raw_code),
      .imm_src    (bus.imm_src),
      .extend_imm (w_dec_imm),
      .illegal    (w_dec_illegal)
   );

   // in_ready is the registered "skid empty" flag, so no accept can coincide with a full skid.
   always_comb begin
      w_accept          = bus.in_valid && r_in_ready;
      w_skid_load       = w_accept && r_out_valid && !bus.out_ready;
      w_skid_drain      = r_skid_valid && bus.out_ready;
      w_skid_valid_next = (r_skid_valid && !bus.out_ready) || w_skid_load;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_in_ready     <= 1'b0;
         r_out_valid    <= 1'b0;
         r_out_imm      <= '0;
         r_out_src      <= '0;
         r_out_illegal  <= 1'b0;
         r_skid_valid   <= 1'b0;
         r_skid_imm     <= '0;
         r_skid_src     <= '0;
         r_skid_illegal <= 1'b0;
         r_err_count    <= '0;
      end else begin
         r_in_ready   <= !w_skid_valid_next;
         r_skid_valid <= w_skid_valid_next;

         if (w_skid_load) begin
            r_skid_imm     <= w_dec_imm;
            r_skid_src     <= bus.imm_src;
            r_skid_illegal <= w_dec_illegal;
         end

         if (w_skid_drain) begin
            r_out_valid   <= 1'b1;
            r_out_imm     <= r_skid_imm;
            r_out_src     <= r_skid_src;
            r_out_illegal <= r_skid_illegal;
         end else if (w_accept && (!r_out_valid || bus.out_ready)) begin
            r_out_valid   <= 1'b1;
            r_out_imm     <= w_dec_imm;
            r_out_src     <= bus.imm_src;
            r_out_illegal <= w_dec_illegal;
         end else if (bus.out_ready) begin
            r_out_valid   <= 1'b0;
         end

         if (w_accept && w_dec_illegal && (r_err_count != '1)) begin
            r_err_count <= r_err_count + 1'b1;
         end
      end
   end

   assign bus.in_ready   = r_in_ready;
   assign bus.out_valid  = r_out_valid;
   assign bus.extend_imm = r_out_imm;
   assign bus.out_src    = r_out_src;
   assign bus.illegal    = r_out_illegal;
   assign bus.err_count  = r_err_count;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: 32- and 64-bit instances share stimulus; a queue model checks every cycle.
module tb_imm_extend_pipe;
   import imm_extend_pipe_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic last_rst = 1'b1;
   always #5 clk = ~clk;
   always @(posedge clk) last_rst <= rst;

   imm_extend_pipe_if #(.XLEN(32), .ERR_CNT_W(8)) bus ();
   imm_extend_pipe_if #(.XLEN(64), .ERR_CNT_W(8)) bus64 ();

   assign bus64.in_valid  = bus.in_valid;
   assign bus64.raw_code  = bus.raw_code;
   assign bus64.imm_src   = bus.imm_src;
   assign bus64.out_ready = bus.out_ready;

   imm_extend_pipe #(.XLEN(32), .ERR_CNT_W(8)) dut32 (.clk(clk), .rst(rst), .bus(bus));
   imm_extend_pipe #(.XLEN(64), .ERR_CNT_W(8)) dut64 (.clk(clk), .rst(rst), .bus(bus64));

   int checks = 0;
   int passes = 0;
   int n_acc  = 0;
   int n_pop  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else passes++;
   endtask

   // Immediate computed from the standard instruction bit positions (instr = {raw, 7'b0}).
   function automatic logic [63:0] model_imm(input logic [24:0] raw, input logic [2:0] src);
      logic [31:0]        ins;
      logic signed [11:0] v12;
      logic signed [12:0] v13;
      logic signed [20:0] v21;
      logic signed [31:0] v32;
      longint             v;
      ins = {raw, 7'b0};
      v   = 0;
      case (src)
         3'd0: begin v12 = ins[31:20]; v = v12; end
         3'd1: begin v12 = {ins[31:25], ins[11:7]}; v = v12; end
         3'd2: begin v13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; v = v13; end
         3'd3: begin v32 = {ins[31:12], 12'b0}; v = v32; end
         3'd4: begin v21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; v = v21; end
         default: v = 0;
      endcase
      return v;
   endfunction

   typedef struct {
      logic [63:0] imm;
      logic [2:0]  src;
      logic        ill;
   } exp_t;

   exp_t        q[$];
   int          model_err = 0;
   logic        hold = 1'b0;
   logic [31:0] prev_imm;
   logic [2:0]  prev_src;
   logic        prev_ill;

   always @(negedge clk) begin
      exp_t e;
      if (last_rst) begin
         check("rst_out_valid", bus.out_valid, 0);
         check("rst_in_ready", bus.in_ready, 0);
         check("rst_extend_imm", bus.extend_imm, 0);
         check("rst_out_src", bus.out_src, 0);
         check("rst_illegal", bus.illegal, 0);
         check("rst_err_count", bus.err_count, 0);
         q.delete();
         model_err = 0;
         hold      = 1'b0;
      end else begin
         check("in_ready", bus.in_ready, (q.size() < 2) ? 1 : 0);
         check("out_valid", bus.out_valid, (q.size() != 0) ? 1 : 0);
         check("out_valid64", bus64.out_valid, (q.size() != 0) ? 1 : 0);
         check("err_count", bus.err_count, model_err);
         if (hold) begin
            check("hold_imm", bus.extend_imm, prev_imm);
            check("hold_src", bus.out_src, prev_src);
            check("hold_ill", bus.illegal, prev_ill);
         end
         if (bus.out_valid && bus.out_ready && q.size() > 0) begin
            e = q.pop_front();
            n_pop++;
            check("res_imm32", bus.extend_imm, e.imm[31:0]);
            check("res_imm64", bus64.extend_imm, e.imm);
            check("res_src", bus.out_src, e.src);
            check("res_illegal", bus.illegal, e.ill);
         end
         if (bus.in_valid && bus.in_ready) begin
            e.imm = model_imm(bus.raw_code, bus.imm_src);
            e.src = bus.imm_src;
            e.ill = (bus.imm_src > 3'd4);
            q.push_back(e);
            n_acc++;
            if (e.ill && model_err < 255) model_err++;
         end
         hold     = bus.out_valid && !bus.out_ready;
         prev_imm = bus.extend_imm;
         prev_src = bus.out_src;
         prev_ill = bus.illegal;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one request and hold it until it is accepted (bounded).
   task automatic push(input logic [24:0] raw, input logic [2:0] src);
      int   budget;
      logic fired;
      bus.in_valid = 1'b1;
      bus.raw_code = raw;
      bus.imm_src  = src;
      budget = 0;
      fired  = 1'b0;
      while (!fired && budget < 50) begin
         @(negedge clk);
         fired = bus.in_ready;
         step();
         budget++;
      end
      bus.in_valid = 1'b0;
      if (!fired) check("push_timeout", 0, 1);
   endtask

   logic [31:0] lit_instr [5] = '{32'hFFF00093, 32'h0020A423, 32'hFE000EE3, 32'h123452B7, 32'h008000EF};
   logic [2:0]  lit_src   [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
   logic [31:0] lit_exp   [5] = '{32'hFFFFFFFF, 32'h00000008, 32'hFFFFFFFC, 32'h12345000, 32'h00000008};

   initial begin
      logic [31:0] ins;
      logic [63:0] m;
      int          base;
      bus.in_valid  = 1'b0;
      bus.raw_code  = '0;
      bus.imm_src   = '0;
      bus.out_ready = 1'b0;
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      step();
      @(negedge clk);
      check("in_ready_after_rst", bus.in_ready, 1);

      // Decode literals, also pinning the model.
      bus.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         ins = lit_instr[i];
         m   = model_imm(ins[31:7], lit_src[i]);
         check("model_lit", m[31:0], lit_exp[i]);
         push(ins[31:7], lit_src[i]);
         @(negedge clk);
         check("dec_valid", bus.out_valid, 1);
         check("dec_lit", bus.extend_imm, lit_exp[i]);
      end
      step();

      // Streaming: 10 back-to-back requests.
      base = n_pop;
      for (int i = 0; i < 10; i++) push(25'(32'h0A5A5A5 * (i + 1)), 3'(i % 5));
      repeat (3) step();
      check("stream_count", n_pop - base, 10);

      // Backpressure: 4 stalled cycles while three requests are offered.
      bus.out_ready = 1'b0;
      base = n_acc;
      fork
         begin
            push(25'h1F0F0F0, 3'd0);
            push(25'h0123456, 3'd2);
            push(25'h1FFFFFF, 3'd4);
         end
         begin
            repeat (4) step();
            check("bp_accepted", n_acc - base, 2);
            bus.out_ready = 1'b1;
         end
      join
      repeat (4) step();
      check("bp_all_accepted", n_acc - base, 3);

      // Illegal format and counter saturation.
      push(25'h1ABCDE, 3'd7);
      @(negedge clk);
      check("ill_imm", bus.extend_imm, 0);
      check("ill_flag", bus.illegal, 1);
      check("ill_err1", bus.err_count, 1);
      for (int i = 0; i < 299; i++) push(25'(i * 977), 3'(5 + (i % 3)));
      repeat (2) step();
      check("err_saturate", bus.err_count, 255);

      // U format with bit 31 set: 64-bit instance must sign-extend.
      push(25'h1000000, 3'd3);
      @(negedge clk);
      check("u64_imm", bus64.extend_imm, 64'hFFFFFFFF80000000);
      check("u32_imm", bus.extend_imm, 32'h80000000);
      step();

      // Random traffic and backpressure.
      for (int i = 0; i < 80; i++) begin
         bus.in_valid  = 1'($urandom_range(0, 1));
         bus.raw_code  = 25'($urandom);
         bus.imm_src   = 3'($urandom_range(0, 7));
         bus.out_ready = 1'($urandom_range(0, 1));
         step();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (4) step();

      // Reset with both stages full.
      bus.out_ready = 1'b0;
      push(25'h0F0F0F0, 3'd1);
      push(25'h1234567, 3'd7);
      rst = 1'b1;
      step();
      @(negedge clk);
      check("midrst_out_valid", bus.out_valid, 0);
      check("midrst_err", bus.err_count, 0);
      rst = 1'b0;
      bus.out_ready = 1'b1;
      step();
      @(negedge clk);
      check("midrst_in_ready", bus.in_ready, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("no_stale", bus.out_valid, 0);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
